// File: rtl/axi4_host_pkg.sv
// axi4_host_pkg: shared types and constants for the single-outstanding AXI4 host master.
// Contents: FSM state enum, AXI burst/response encodings, AxSIZE-from-strobe-width helper.
package axi4_host_pkg;
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    function automatic logic [2:0] size_from_strb(input int strb_width);
        return 3'($clog2(strb_width));
    endfunction
endpackage

// File: rtl/axi4_host_master.sv
// axi4_host_master: converts single-beat commands into AXI4 write/read transactions, one at a time.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_write      command handshake and direction (1 = write)
//   cmd_id/addr/wdata/wstrb         command fields, latched on accept
//   rsp_valid/ready                 completion handshake
//   rsp_write/rdata/resp/err        completion type, read data, AXI resp, protocol-error flag
//   hostCtrl_aw*/w*/b*/ar*/r*       AXI4 master channels (single beat, INCR, registered outputs)
module axi4_host_master
    import axi4_host_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int TIMEOUT    = 1023,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_err,
    output logic                  hostCtrl_awvalid,
    input  logic                  hostCtrl_awready,
    output logic [ID_WIDTH-1:0]   hostCtrl_awid,
    output logic [ADDR_WIDTH-1:0] hostCtrl_awaddr,
    output logic [7:0]            hostCtrl_awlen,
    output logic [2:0]            hostCtrl_awsize,
    output logic [1:0]            hostCtrl_awburst,
    output logic                  hostCtrl_awlock,
    output logic [3:0]            hostCtrl_awcache,
    output logic [2:0]            hostCtrl_awprot,
    output logic                  hostCtrl_wvalid,
    input  logic                  hostCtrl_wready,
    output logic [DATA_WIDTH-1:0] hostCtrl_wdata,
    output logic [STRB_WIDTH-1:0] hostCtrl_wstrb,
    output logic                  hostCtrl_wlast,
    input  logic                  hostCtrl_bvalid,
    output logic                  hostCtrl_bready,
    input  logic [ID_WIDTH-1:0]   hostCtrl_bid,
    input  logic [1:0]            hostCtrl_bresp,
    output logic                  hostCtrl_arvalid,
    input  logic                  hostCtrl_arready,
    output logic [ID_WIDTH-1:0]   hostCtrl_arid,
    output logic [ADDR_WIDTH-1:0] hostCtrl_araddr,
    output logic [7:0]            hostCtrl_arlen,
    output logic [2:0]            hostCtrl_arsize,
    output logic [1:0]            hostCtrl_arburst,
    output logic                  hostCtrl_arlock,
    output logic [3:0]            hostCtrl_arcache,
    output logic [2:0]            hostCtrl_arprot,
    input  logic                  hostCtrl_rvalid,
    output logic                  hostCtrl_rready,
    input  logic [ID_WIDTH-1:0]   hostCtrl_rid,
    input  logic [DATA_WIDTH-1:0] hostCtrl_rdata,
    input  logic [1:0]            hostCtrl_rresp,
    input  logic                  hostCtrl_rlast
);
    // Width 1 when the timeout is disabled so the counter stays a legal vector.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt;
    logic                  expired;
    logic                  write_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;

    // Counter holds the number of completed waiting cycles; the last one expires here.
    assign expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

    assign hostCtrl_awid    = id_q;
    assign hostCtrl_awaddr  = addr_q;
    assign hostCtrl_awlen   = 8'd0;
    assign hostCtrl_awsize  = size_from_strb(STRB_WIDTH);
    assign hostCtrl_awburst = BURST_INCR;
    assign hostCtrl_awlock  = 1'b0;
    assign hostCtrl_awcache = 4'd0;
    assign hostCtrl_awprot  = 3'd0;
    assign hostCtrl_wdata   = wdata_q;
    assign hostCtrl_wstrb   = wstrb_q;
    assign hostCtrl_wlast   = 1'b1;
    assign hostCtrl_arid    = id_q;
    assign hostCtrl_araddr  = addr_q;
    assign hostCtrl_arlen   = 8'd0;
    assign hostCtrl_arsize  = size_from_strb(STRB_WIDTH);
    assign hostCtrl_arburst = BURST_INCR;
    assign hostCtrl_arlock  = 1'b0;
    assign hostCtrl_arcache = 4'd0;
    assign hostCtrl_arprot  = 3'd0;
    assign rsp_write        = write_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // WADDR leaves once each channel has either finished earlier (valid already low) or completes now.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_ready) state_n = cmd_write ? WADDR : RADDR;
            WADDR:   if ((!hostCtrl_awvalid || hostCtrl_awready) && (!hostCtrl_wvalid || hostCtrl_wready)) state_n = WRESP;
            WRESP:   if (hostCtrl_bvalid || expired) state_n = RSP;
            RADDR:   if (hostCtrl_arready) state_n = RDATA;
            RDATA:   if (hostCtrl_rvalid || expired) state_n = RSP;
            RSP:     if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready        <= 1'b0;
            hostCtrl_awvalid <= 1'b0;
            hostCtrl_wvalid  <= 1'b0;
            hostCtrl_arvalid <= 1'b0;
            hostCtrl_bready  <= 1'b0;
            hostCtrl_rready  <= 1'b0;
            rsp_valid        <= 1'b0;
        end else begin
            cmd_ready        <= state_n == IDLE;
            hostCtrl_awvalid <= state_n == WADDR && (state == IDLE || (hostCtrl_awvalid && !hostCtrl_awready));
            hostCtrl_wvalid  <= state_n == WADDR && (state == IDLE || (hostCtrl_wvalid && !hostCtrl_wready));
            hostCtrl_arvalid <= state_n == RADDR;
            hostCtrl_bready  <= state_n == WRESP;
            hostCtrl_rready  <= state_n == RDATA;
            rsp_valid        <= state_n == RSP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (state_n == state && (state == WRESP || state == RDATA)) ? cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (state == IDLE && cmd_valid && cmd_ready) begin
            write_q <= cmd_write;
            id_q    <= cmd_id;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    // A real B/R beat wins over a timeout expiring in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            rsp_err   <= 1'b0;
        end else if (state == WRESP && hostCtrl_bvalid) begin
            rsp_rdata <= '0;
            rsp_resp  <= hostCtrl_bresp;
            rsp_err   <= hostCtrl_bid != id_q;
        end else if (state == RDATA && hostCtrl_rvalid) begin
            rsp_rdata <= hostCtrl_rdata;
            rsp_resp  <= hostCtrl_rresp;
            rsp_err   <= (hostCtrl_rid != id_q) || !hostCtrl_rlast;
        end else if ((state == WRESP || state == RDATA) && expired) begin
            rsp_rdata <= '0;
            rsp_resp  <= RESP_SLVERR;
            rsp_err   <= 1'b1;
        end
    end
endmodule

// File: doc/axi4_host_master.md
AXI4_HOST_MASTER -- requirements
Module: axi4_host_master

Interface
REQ-001 DATA_WIDTH, 32, AXI data width in bits; legal values 32 or 64; STRB_WIDTH = DATA_WIDTH/8.
REQ-002 ADDR_WIDTH, 16, AXI address width in bits.
REQ-003 ID_WIDTH, 8, AXI ID width in bits.
REQ-004 TIMEOUT, 1023, cycles to wait for B/R before abort; 0 disables the timeout.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_id / cmd_addr / cmd_wdata / cmd_wstrb  in  ID_WIDTH / ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH  transaction fields.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_write / rsp_rdata / rsp_resp / rsp_err  out  1 / DATA_WIDTH / 2 / 1  completion type, read data, AXI resp, protocol-error flag.
REQ-012 hostCtrl_awvalid out 1, hostCtrl_awready in 1; awid / awaddr / awlen / awsize / awburst / awlock / awcache / awprot  out  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2 / 1 / 4 / 3.
REQ-013 hostCtrl_wvalid out 1, hostCtrl_wready in 1; wdata / wstrb / wlast  out  DATA_WIDTH / STRB_WIDTH / 1.
REQ-014 hostCtrl_bvalid in 1, hostCtrl_bready out 1, hostCtrl_bid in ID_WIDTH, hostCtrl_bresp in 2.
REQ-015 hostCtrl_ar* is the same set as aw*: arvalid out, arready in, arid / araddr / arlen / arsize / arburst / arlock / arcache / arprot out, same widths as REQ-012.
REQ-016 hostCtrl_rvalid in 1, hostCtrl_rready out 1, rid in ID_WIDTH, rdata in DATA_WIDTH, rresp in 2, rlast in 1.

Function
REQ-017 At most one transaction outstanding; cmd_ready = 1 only in IDLE.
REQ-018 FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
REQ-019 IDLE, on cmd handshake: latch all cmd fields; write -> WADDR, read -> RADDR.
REQ-020 All AXI outputs are registered; no combinational path from cmd_* to hostCtrl_*; aw/ar valid first asserts the cycle after cmd accept.
REQ-021 Constant fields:
- len = 0
- size = log2(STRB_WIDTH)
- burst = INCR (01)
- lock = 0, cache = 0000, prot = 000
- wlast = 1
REQ-022 WADDR:
- awvalid and wvalid assert together; each deasserts only after its own handshake.
- Payload is stable while valid.
- Go to WRESP once both handshakes are done, in either order or in the same cycle.
REQ-023 WRESP: bready = 1; on bvalid, capture bresp, set rsp_err if bid != latched id, go to RSP.
REQ-024 RADDR: hold arvalid until arready, then go to RDATA.
REQ-025 RDATA: rready = 1; on rvalid, capture rdata and rresp; set rsp_err if rid mismatches or rlast = 0; go to RSP.
REQ-026 Timeout counter:
- Width clog2(TIMEOUT+1); cleared on entry to WRESP/RDATA; +1 per waiting cycle.
- At TIMEOUT: go to RSP with rsp_resp = 10, rsp_err = 1, rsp_rdata = 0.
- A B/R handshake in the same cycle as the timeout takes priority over the timeout.
REQ-027 A stray response after a timeout is consumed by the next transaction's WRESP/RDATA and flagged only through the ID compare.
REQ-028 RSP: rsp_valid = 1 with fields stable until rsp_ready; then go to IDLE, with no same-cycle bypass to a new command.
REQ-029 Zero-wait-state latency:
- Write: accept at cycle 0, AW/W at cycle 1, B at cycle 2, rsp_valid at cycle 3.
- Read: same timing (AR at cycle 1, R at cycle 2, rsp_valid at cycle 3).

Reset
REQ-030 While rst_n is low: state = IDLE, every output = 0 (including cmd_ready), latched registers and counter = 0; constant fields keep their REQ-021 values.
REQ-031 Reset mid-transaction abandons the transaction with no response; rst_n deassertion is synchronized to clk externally; cmd_ready = 1 from the first clock after release.

Structure
REQ-032 Package axi4_host_pkg holds:
- state enum
- BURST_INCR, RESP_OKAY, RESP_SLVERR constants
- size-from-strobe-width function
REQ-033 Single module, no sub-modules; the timeout counter is inline.

Verification
REQ-034 Write 0x0040 / 0xDEADBEEF / strb F / id 3, slave always ready, bresp 00, bid 3 -> AW and W fields correct at cycle 1, rsp_valid at cycle 3, rsp_resp 00, rsp_err 0.
REQ-035 Write where wready arrives 3 cycles before awready -> wvalid drops after the W handshake, awvalid held, exactly one B accepted and one response.
REQ-036 Read 0x0100 id 5, slave returns rid 5, 0x12345678, rlast 1 after 4 cycles -> rsp_rdata 0x12345678, rsp_resp 00, rsp_err 0; repeat with rid 6 or rlast 0 -> rsp_err 1.
REQ-037 TIMEOUT = 8, bvalid never asserted -> rsp_valid 8 cycles after WRESP entry, rsp_resp 10, rsp_err 1.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp fields stable and cmd_ready 0 throughout.
REQ-039 rst_n low during WADDR -> all outputs 0 immediately; after release cmd_ready 1 and no response is issued.
